// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared state encodings and sizing helper for the
// MM:SS countdown timer control sequencer.
package timer_ctrl_pkg;

   // Sequencer states; the encoding is visible on the state output port
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } timerState_t;

   // Width of a counter that must hold values 0..div-1, never narrower than 1 bit
   function automatic int counterWidth(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/timer_ctrl_rate.sv
// rate_counter: terminal-count counter running 0..DIV-1.
// i_clr has priority over i_en and forces the count back to zero.
// o_tc is a one-cycle strobe in the cycle that the counter sits on its
// last value while enabled; that same edge wraps the count to zero.
// When enable drops, the count is held, which lets the prescaler pause.
module rate_counter
   import timer_ctrl_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int W = counterWidth(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] r_count;

   assign o_tc = i_en && !i_clr && (r_count == LAST);

   // Count enabled cycles, wrapping back to zero only at the terminal value
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         if (r_count == LAST) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: control sequencer for the MM:SS BCD countdown timer.
// Turns debounced button levels and the datapath zero flag into one-cycle
// increment / decrement / clear strobes, plus display blank and alarm.
// Event priority in any cycle: clear edge, then start edge, then
// increment (edge or auto-repeat), then the countdown tick.
module timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int HOLD_DIV   = 25_000_000,
   parameter int REPEAT_DIV = 5_000_000,
   parameter int BLINK_DIV  = 12_500_000,
   parameter int ALARM_SECS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_btn,
   input  logic       inc_btn,
   input  logic       clr_btn,
   input  logic       zero,
   output logic       inc_en,
   output logic       dec_en,
   output logic       clr,
   output logic       blank,
   output logic       alarm,
   output logic [1:0] state
);

   localparam int AW = counterWidth(ALARM_SECS);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

   timerState_t r_state;
   logic        r_incEn;
   logic        r_decEn;
   logic        r_clr;
   logic        r_blank;
   logic        r_alarm;
   logic [AW-1:0] r_alarmSecs;
   logic        r_repeating;
   logic        r_startPrev;
   logic        r_incPrev;
   logic        r_clrPrev;

   logic w_startEdge;
   logic w_incEdge;
   logic w_clrEdge;
   logic w_inIncState;
   logic w_incStop;
   logic w_incEvent;
   logic w_expUserExit;
   logic w_tickClr;
   logic w_tickEn;
   logic w_tickTc;
   logic w_holdClr;
   logic w_holdEn;
   logic w_holdTc;
   logic w_repeatClr;
   logic w_repeatEn;
   logic w_repeatTc;
   logic w_blinkClr;
   logic w_blinkEn;
   logic w_blinkTc;

   assign inc_en = r_incEn;
   assign dec_en = r_decEn;
   assign clr    = r_clr;
   assign blank  = r_blank;
   assign alarm  = r_alarm;
   assign state  = r_state;

   // Rising edges: level high now, registered copy still low
   assign w_startEdge = start_btn & ~r_startPrev;
   assign w_incEdge   = inc_btn   & ~r_incPrev;
   assign w_clrEdge   = clr_btn   & ~r_clrPrev;

   // Increment handling only exists in IDLE and PAUSE; any higher-priority
   // event or a release aborts the hold/repeat sequence
   assign w_inIncState = (r_state == ST_IDLE) || (r_state == ST_PAUSE);
   assign w_incStop    = ~inc_btn | ~w_inIncState | w_clrEdge | w_startEdge;
   assign w_incEvent   = w_inIncState & ~w_clrEdge & ~w_startEdge &
                         (w_incEdge | w_holdTc | w_repeatTc);

   // Hold phase counts while the button stays high after its edge
   assign w_holdClr   = w_incStop | r_repeating;
   assign w_holdEn    = r_incPrev & ~r_repeating;

   // Repeat phase takes over once the hold period has elapsed
   assign w_repeatClr = w_incStop | ~r_repeating;
   assign w_repeatEn  = r_repeating;

   // Prescaler: zero in IDLE so RUN always starts a fresh second; it freezes
   // in PAUSE and on the pausing edge so a resume continues mid-second
   assign w_expUserExit = (r_state == ST_EXPIRED) && (w_startEdge || w_incEdge);
   assign w_tickClr     = w_clrEdge || (r_state == ST_IDLE) || w_expUserExit;
   assign w_tickEn      = ((r_state == ST_RUN) && !w_startEdge) ||
                          (r_state == ST_EXPIRED);

   // Blink divider only runs in EXPIRED so blanking always starts with a full phase
   assign w_blinkClr = (r_state != ST_EXPIRED);
   assign w_blinkEn  = (r_state == ST_EXPIRED);

   rate_counter #(.DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_tickClr),
      .i_en  (w_tickEn),
      .o_tc  (w_tickTc)
   );

   rate_counter #(.DIV(HOLD_DIV)) u_hold (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_holdClr),
      .i_en  (w_holdEn),
      .o_tc  (w_holdTc)
   );

   rate_counter #(.DIV(REPEAT_DIV)) u_repeat (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_repeatClr),
      .i_en  (w_repeatEn),
      .o_tc  (w_repeatTc)
   );

   rate_counter #(.DIV(BLINK_DIV)) u_blink (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_blinkClr),
      .i_en  (w_blinkEn),
      .o_tc  (w_blinkTc)
   );

   // Button history; reset to 1 so a button held through reset gives no edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_startPrev <= 1'b1;
         r_incPrev   <= 1'b1;
         r_clrPrev   <= 1'b1;
      end else begin
         r_startPrev <= start_btn;
         r_incPrev   <= inc_btn;
         r_clrPrev   <= clr_btn;
      end
   end

   // Auto-repeat mode flag: set when the hold period completes, dropped on release or abort
   always_ff @(posedge clk) begin
      if (reset) begin
         r_repeating <= 1'b0;
      end else if (w_incStop) begin
         r_repeating <= 1'b0;
      end else if (w_holdTc) begin
         r_repeating <= 1'b1;
      end
   end

   // Main sequencer with registered strobes, blank and alarm
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_incEn     <= 1'b0;
         r_decEn     <= 1'b0;
         r_clr       <= 1'b0;
         r_blank     <= 1'b0;
         r_alarm     <= 1'b0;
         r_alarmSecs <= '0;
      end else begin
         r_incEn <= 1'b0;
         r_decEn <= 1'b0;
         r_clr   <= 1'b0;
         if (w_clrEdge) begin
            r_clr       <= 1'b1;
            r_state     <= ST_IDLE;
            r_blank     <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarmSecs <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_blank     <= 1'b0;
                  r_alarm     <= 1'b0;
                  r_alarmSecs <= '0;
                  if (w_startEdge) begin
                     if (!zero) begin
                        r_state <= ST_RUN;
                     end
                  end else if (w_incEvent) begin
                     r_incEn <= 1'b1;
                  end
               end
               ST_RUN: begin
                  r_blank     <= 1'b0;
                  r_alarmSecs <= '0;
                  if (w_startEdge) begin
                     r_state <= ST_PAUSE;
                  end else if (w_tickTc) begin
                     if (zero) begin
                        r_state <= ST_EXPIRED;
                        r_alarm <= 1'b1;
                     end else begin
                        r_decEn <= 1'b1;
                     end
                  end
               end
               ST_PAUSE: begin
                  r_blank     <= 1'b0;
                  r_alarmSecs <= '0;
                  if (w_startEdge) begin
                     r_state <= ST_RUN;
                  end else if (w_incEvent) begin
                     r_incEn <= 1'b1;
                  end
               end
               ST_EXPIRED: begin
                  if (w_expUserExit ||
                      (w_tickTc && (r_alarmSecs == ALARM_LAST))) begin
                     r_clr       <= 1'b1;
                     r_state     <= ST_IDLE;
                     r_blank     <= 1'b0;
                     r_alarm     <= 1'b0;
                     r_alarmSecs <= '0;
                  end else begin
                     if (w_tickTc) begin
                        r_alarmSecs <= r_alarmSecs + 1'b1;
                     end
                     if (w_blinkTc) begin
                        r_blank <= ~r_blank;
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for the countdown timer sequencer, using
// short dividers (tick 4, hold 8, repeat 2, blink 3, alarm 2 seconds).
module tb_timer_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_btn;
   logic       inc_btn;
   logic       clr_btn;
   logic       zero;
   logic       inc_en;
   logic       dec_en;
   logic       clr;
   logic       blank;
   logic       alarm;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   timer_ctrl #(
      .TICK_DIV   (4),
      .HOLD_DIV   (8),
      .REPEAT_DIV (2),
      .BLINK_DIV  (3),
      .ALARM_SECS (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start_btn (start_btn),
      .inc_btn   (inc_btn),
      .clr_btn   (clr_btn),
      .zero      (zero),
      .inc_en    (inc_en),
      .dec_en    (dec_en),
      .clr       (clr),
      .blank     (blank),
      .alarm     (alarm),
      .state     (state)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start_btn = 1'b0; inc_btn = 1'b0; clr_btn = 1'b0; zero = 1'b0;
      step(); step();
      checks++;
      if ({inc_en, dec_en, clr, blank, alarm, state} !== 7'd0) begin
         errors++;
         $display("[TB] FAIL reset_values: got %b expected %b",
                  {inc_en, dec_en, clr, blank, alarm, state}, 7'd0);
      end
      reset = 1'b0;
      step();
      checks++;
      if ({inc_en, dec_en, clr, state} !== 5'd0) begin
         errors++;
         $display("[TB] FAIL after_reset_idle: got %b expected %b",
                  {inc_en, dec_en, clr, state}, 5'd0);
      end
   endtask

   task automatic test_single_inc();
      int pulses = 0;
      for (int k = 0; k < 3; k++) begin
         inc_btn = 1'b1;
         step();
         checks++;
         if (inc_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_inc_edge%0d: got %b expected 1", k, inc_en);
         end
         if (inc_en === 1'b1) pulses++;
         inc_btn = 1'b0;
         for (int j = 0; j < 3; j++) begin
            step();
            if (inc_en === 1'b1) pulses++;
         end
      end
      checks++;
      if (pulses !== 3) begin
         errors++;
         $display("[TB] FAIL single_inc_count: got %0d expected 3", pulses);
      end
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("[TB] FAIL single_inc_state: got %0d expected 0", state);
      end
   endtask

   task automatic test_hold_repeat();
      logic [19:0] seen;
      seen = '0;
      inc_btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         seen[i] = inc_en;
         if (i == 14) inc_btn = 1'b0;
      end
      checks++;
      if (seen !== 20'h05501) begin
         errors++;
         $display("[TB] FAIL hold_repeat_pattern: got %h expected %h", seen, 20'h05501);
      end
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("[TB] FAIL hold_repeat_state: got %0d expected 0", state);
      end
   endtask

   task automatic test_start_zero();
      logic [11:0] decSeen;
      zero = 1'b1; start_btn = 1'b1;
      step();
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("[TB] FAIL start_at_zero: got state %0d expected 0", state);
      end
      start_btn = 1'b0;
      step();
      zero = 1'b0; start_btn = 1'b1;
      step();
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("[TB] FAIL start_run: got state %0d expected 1", state);
      end
      start_btn = 1'b0;
      decSeen = '0;
      for (int i = 0; i < 12; i++) begin
         step();
         decSeen[i] = dec_en;
      end
      checks++;
      if (decSeen !== 12'h888) begin
         errors++;
         $display("[TB] FAIL dec_cadence: got %h expected %h", decSeen, 12'h888);
      end
   endtask

   task automatic test_pause();
      int decCount = 0;
      logic [3:0] resumeSeen;
      step(); step();
      start_btn = 1'b1;
      step();
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("[TB] FAIL pause_enter: got state %0d expected 2", state);
      end
      start_btn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dec_en === 1'b1) decCount++;
      end
      checks++;
      if (decCount !== 0 || state !== 2'd2) begin
         errors++;
         $display("[TB] FAIL pause_hold: got dec=%0d state=%0d expected dec=0 state=2",
                  decCount, state);
      end
      start_btn = 1'b1;
      step();
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("[TB] FAIL pause_resume: got state %0d expected 1", state);
      end
      start_btn = 1'b0;
      resumeSeen = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         resumeSeen[i] = dec_en;
      end
      checks++;
      if (resumeSeen !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL resume_dec: got %b expected %b", resumeSeen, 4'b0010);
      end
   endtask

   task automatic test_expire();
      logic [6:0] blankSeen;
      logic [7:0] clrSeen;
      logic       stayed;
      zero = 1'b1;
      step();
      checks++;
      if ({state, dec_en} !== {2'd1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL expire_pre: got state=%0d dec=%b expected state=1 dec=0",
                  state, dec_en);
      end
      step();
      checks++;
      if ({state, alarm, dec_en, blank} !== {2'd3, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL expire_enter: got state=%0d alarm=%b dec=%b blank=%b expected 3 1 0 0",
                  state, alarm, dec_en, blank);
      end
      blankSeen = '0;
      clrSeen = '0;
      stayed = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i < 7) begin
            blankSeen[i] = blank;
            if (state !== 2'd3 || alarm !== 1'b1) stayed = 1'b0;
         end
         clrSeen[i] = clr;
      end
      checks++;
      if (blankSeen !== 7'b0011100) begin
         errors++;
         $display("[TB] FAIL blink_pattern: got %b expected %b", blankSeen, 7'b0011100);
      end
      checks++;
      if (stayed !== 1'b1) begin
         errors++;
         $display("[TB] FAIL expired_hold: got %b expected 1", stayed);
      end
      checks++;
      if (clrSeen !== 8'b1000_0000) begin
         errors++;
         $display("[TB] FAIL alarm_timeout_clr: got %b expected %b", clrSeen, 8'b1000_0000);
      end
      checks++;
      if ({state, blank, alarm} !== 4'd0) begin
         errors++;
         $display("[TB] FAIL alarm_return_idle: got state=%0d blank=%b alarm=%b expected 0 0 0",
                  state, blank, alarm);
      end
   endtask

   task automatic test_clr_priority();
      zero = 1'b0; start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      step();
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      step();
      checks++;
      if (state !== 2'd2) begin
         errors++;
         $display("[TB] FAIL clr_setup_pause: got state %0d expected 2", state);
      end
      clr_btn = 1'b1; start_btn = 1'b1;
      step();
      checks++;
      if ({clr, inc_en, dec_en, state} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
         errors++;
         $display("[TB] FAIL clr_over_start: got clr=%b inc=%b dec=%b state=%0d expected 1 0 0 0",
                  clr, inc_en, dec_en, state);
      end
      clr_btn = 1'b0; start_btn = 1'b0;
      step();
      checks++;
      if ({clr, state} !== 3'd0) begin
         errors++;
         $display("[TB] FAIL clr_one_cycle: got clr=%b state=%0d expected 0 0", clr, state);
      end
   endtask

   task automatic test_reset_mid_expired();
      int n = 0;
      zero = 1'b0; start_btn = 1'b1;
      step();
      start_btn = 1'b0; zero = 1'b1;
      while (state !== 2'd3 && n < 10) begin
         step();
         n++;
      end
      checks++;
      if (n !== 4) begin
         errors++;
         $display("[TB] FAIL expire_latency: got %0d cycles expected 4", n);
      end
      step(); step(); step();
      checks++;
      if (blank !== 1'b1) begin
         errors++;
         $display("[TB] FAIL blank_before_reset: got %b expected 1", blank);
      end
      start_btn = 1'b1; reset = 1'b1;
      step();
      checks++;
      if ({inc_en, dec_en, clr, blank, alarm, state} !== 7'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_expired: got %b expected %b",
                  {inc_en, dec_en, clr, blank, alarm, state}, 7'd0);
      end
      zero = 1'b0;
      step();
      reset = 1'b0;
      step();
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("[TB] FAIL held_start_no_edge: got state %0d expected 0", state);
      end
      start_btn = 1'b0;
      step();
   endtask

   // Run the scenarios in order, then report
   initial begin
      test_reset();
      test_single_inc();
      test_hold_repeat();
      test_start_zero();
      test_pause();
      test_expire();
      test_clr_priority();
      test_reset_mid_expired();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
